adc_stream_framer: RTL

Framing stage between the ADC channel arbiter and the SRAM FIFO.
- Consumes arbitrated 32-bit ADC words through a valid/ready handshake.
- Groups them into fixed-length frames; each frame starts with a header word carrying a frame counter and a timestamp.
- Buffers the result in a first-word-fall-through (FWFT) FIFO whose EMPTY/READ/DATA interface matches the SRAM FIFO input side.

---
 rtl/adc_stream_framer_if.sv | 20 ++
 rtl/adc_stream_framer.sv | 107 ++++++++++
 2 files changed

// File: rtl/adc_stream_framer_if.sv
// Stream interface between the ADC arbiter, the framer and the SRAM FIFO.
// master: arbiter/reader side; slave: framer side (IN_* in, OUT_* FWFT out).
interface adc_stream_framer_if;
  logic [31:0] IN_DATA;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] OUT_DATA;
  logic        OUT_EMPTY;
  logic        OUT_READ;

  modport master (
    output IN_DATA, IN_VALID, OUT_READ,
    input  IN_READY, OUT_DATA, OUT_EMPTY
  );

  modport slave (
    input  IN_DATA, IN_VALID, OUT_READ,
    output IN_READY, OUT_DATA, OUT_EMPTY
  );
endinterface

// File: rtl/adc_stream_framer.sv
// Frames ADC words (header {E,FRAME_CNT,TS} + FRAME_WORDS data) into a FWFT FIFO.
// Ports: BUS_CLK, BUS_RST (sync, high), ENABLE, bus (stream if), FRAME_CNT, BUSY.
module adc_stream_framer #(
  parameter int FRAME_WORDS = 16,
  parameter int DEPTH       = 64
) (
  input  logic                  BUS_CLK,
  input  logic                  BUS_RST,
  input  logic                  ENABLE,
  adc_stream_framer_if.slave    bus,
  output logic [11:0]           FRAME_CNT,
  output logic                  BUSY
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [WW-1:0] LAST = WW'(FRAME_WORDS - 1);

  typedef enum logic {IDLE, DATA} state_t;

  state_t        state;
  logic [15:0]   ts;
  logic [WW-1:0] wcnt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic        full;
  logic        empty;
  logic        in_ready;
  logic        start;
  logic        xfer;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wr_data;

  assign full     = (count == FULL);
  assign empty    = (count == '0);
  assign in_ready = (state == DATA) && !full;
  assign start    = (state == IDLE) && ENABLE && bus.IN_VALID && !full;
  assign xfer     = in_ready && bus.IN_VALID;
  assign wr_en    = start || xfer;
  assign rd_en    = bus.OUT_READ && !empty;
  assign wr_data  = start ? {4'hE, FRAME_CNT, ts} : bus.IN_DATA;

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_EMPTY = empty;
  assign bus.OUT_DATA  = empty ? 32'd0 : mem[rd_ptr];

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state     <= IDLE;
      BUSY      <= 1'b0;
      wcnt      <= '0;
      FRAME_CNT <= '0;
      ts        <= '0;
    end else begin
      ts <= ts + 16'd1;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= DATA;
            BUSY  <= 1'b1;
            wcnt  <= '0;
          end
        end
        DATA: begin
          if (xfer) begin
            if (wcnt == LAST) begin
              state     <= IDLE;
              BUSY      <= 1'b0;
              FRAME_CNT <= FRAME_CNT + 12'd1;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Full is judged on the registered count, so a pop at full
  // frees a slot only from the following cycle.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        wr_en && !rd_en: count <= count + 1'b1;
        rd_en && !wr_en: count <= count - 1'b1;
        default:         count <= count;
      endcase
    end
  end

endmodule
